// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered read data and registered occupancy/flags.
// Optional overflow/underflow pulse outputs when SYNC_FIFO_ERR_FLAGS_EN is defined.
module sync_fifo #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    Wr_enable,
    input  logic                    Read_enable,
    input  logic [DATA_WIDTH-1:0]   data_in,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    ,
    output logic                    overflow,
    output logic                    underflow
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]         count_q, count_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  rd_accept_c;
    logic                  wr_accept_c;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
`endif

    // Accept logic: a read frees a slot for a same-cycle write when full.
    always_comb begin
        rd_accept_c = Read_enable && !empty_q;
        wr_accept_c = Wr_enable && (!full_q || rd_accept_c);
    end

    // Next-state pointers, occupancy, flags and read data.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        data_out_d = data_out_q;
        if (wr_accept_c) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (rd_accept_c) begin
            rd_ptr_d   = rd_ptr_q + PW'(1);
            data_out_d = mem_q[rd_ptr_q[AW-1:0]];
        end
        count_d = wr_ptr_d - rd_ptr_d;
        empty_d = (wr_ptr_d == rd_ptr_d);
        full_d  = (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]) &&
                  (wr_ptr_d[AW] != rd_ptr_d[AW]);
    end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    always_comb begin
        overflow_d  = Wr_enable && !wr_accept_c;
        underflow_d = Read_enable && !rd_accept_c;
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            data_out_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            data_out_q <= data_out_d;
        end
    end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`endif

    // Storage is intentionally not reset; writes are blocked while reset is held.
    always_ff @(posedge clk) begin
        if (wr_accept_c && reset) begin
            mem_q[wr_ptr_q[AW-1:0]] <= data_in;
        end
    end

    assign data_out = data_out_q;
    assign full     = full_q;
    assign empty    = empty_q;
    assign count    = count_q;

endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the width of data_in and data_out.
REQ-002 Parameter DEPTH, default 8, SHALL set the number of storage entries and SHALL be a power of two, at least 2.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 Wr_enable  input  1  SHALL be the write request, sampled at posedge clk.
REQ-006 Read_enable  input  1  SHALL be the read request, sampled at posedge clk.
REQ-007 data_in  input  DATA_WIDTH  SHALL be the write data, captured on an accepted write.
REQ-008 data_out  output  DATA_WIDTH  SHALL be the registered read data.
REQ-009 full  output  1  SHALL be high when the occupancy equals DEPTH.
REQ-010 empty  output  1  SHALL be high when the occupancy equals 0.
REQ-011 count  output  $clog2(DEPTH)+1  SHALL be the current occupancy, from 0 to DEPTH.

Function
REQ-012 Storage SHALL be DEPTH x DATA_WIDTH registers, addressed by wr_ptr and rd_ptr, each $clog2(DEPTH)+1 bits wide including a wrap bit.
REQ-013 A write SHALL be accepted when Wr_enable=1 and (full=0 or an accepted read occurs in the same cycle): mem[wr_ptr] <= data_in, and wr_ptr increments.
REQ-014 A read SHALL be accepted when Read_enable=1 and empty=0: data_out <= mem[rd_ptr], and rd_ptr increments.
REQ-015 Read latency SHALL be one cycle: the word is valid on data_out after the edge that accepts the read.
REQ-016 data_out SHALL hold its last value in every cycle without an accepted read.
REQ-017 Pointers SHALL wrap modulo 2*DEPTH; the low bits SHALL index storage.
REQ-018 Flags:
- empty SHALL be high when wr_ptr==rd_ptr.
- full SHALL be high when the low bits are equal and the wrap bits differ.
- Both flags SHALL be registered-consistent with count in the same cycle.
REQ-019 count SHALL equal wr_ptr-rd_ptr modulo 2*DEPTH, and SHALL change by +1 on a write only, by -1 on a read only, and by 0 on both or neither.
REQ-020 When full, a write-only request SHALL be dropped, leaving storage, pointers and count unchanged.
REQ-021 When empty, a read-only request SHALL be ignored, leaving data_out and rd_ptr unchanged.
REQ-022 With simultaneous read and write while empty, only the write SHALL be accepted, and the next cycle SHALL have count=1 and empty=0.
REQ-023 With simultaneous read and write while full, both SHALL be accepted and full SHALL remain 1.
REQ-024 The FIFO SHALL keep strict first-in-first-out order across pointer wrap-around.

Reset
REQ-025 reset=0 SHALL immediately, without waiting for clk, force wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, data_out=0.
REQ-026 Storage contents SHALL NOT be reset.
REQ-027 Reset asserted mid-operation SHALL discard all queued data; requests SHALL be ignored while reset=0.
REQ-028 Deassertion SHALL be synchronized by the user; the first accepted request SHALL be at the first posedge with reset=1.

Configuration
REQ-029 Macro SYNC_FIFO_ERR_FLAGS_EN, when defined, SHALL add the following outputs:
- overflow (1 bit): registered, high for one cycle after a dropped write.
- underflow (1 bit): registered, high for one cycle after an ignored read.
- Both SHALL reset to 0.
REQ-030 Without SYNC_FIFO_ERR_FLAGS_EN, the ports and logic of REQ-029 SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-031 Fill-to-full: after reset, write 0x01..0x08 on consecutive cycles -> full=1 and count=8 after the 8th edge; a 9th write of 0xFF is dropped (and overflow pulses if enabled).
REQ-032 Drain order: from the full state, read 8 times -> data_out = 0x01..0x08, each one cycle after its read edge; empty=1 after the 8th; a further read leaves data_out=0x08 (and underflow pulses if enabled).
REQ-033 Wrap-around: write 5, read 5, write 6, read 6 (data 0x10..0x1A) -> output order matches input order and count returns to 0.
REQ-034 Simultaneous read and write: when empty, write 0xA5 with a read -> count=1 and data_out unchanged; when full, write 0x5A with a read -> oldest word is output, full stays 1, 0x5A is read last.
REQ-035 Async reset: with count=4, pull reset low between clock edges -> empty=1, full=0, count=0, data_out=0 immediately; after release, the next read is ignored.
